// File: rtl/cam_sim.sv
// Synthetic VGA camera source: divides clk by two into pclk and streams
// one test-pattern pixel with its coordinates per pclk period.
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-high reset
//   pclk   out  pixel clock (clk/2, registered)
//   value  out  [7:0] pixel intensity
//   x      out  [9:0] column of current pixel
//   y      out  [9:0] row of current pixel
//   is_val out  active-pixel flag
`timescale 1ns/1ps

module cam_sim #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_TOTAL  = 784,
  parameter int V_TOTAL  = 510,
  parameter int PATTERN  = 0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pclk,
  output logic [7:0] value,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       is_val
);

  localparam logic [9:0] HA = 10'(H_ACTIVE);
  localparam logic [9:0] VA = 10'(V_ACTIVE);
  localparam logic [9:0] HL = 10'(H_TOTAL - 1);
  localparam logic [9:0] VL = 10'(V_TOTAL - 1);

  logic       pclk_q;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic [7:0] frame_q, frame_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [7:0] val_q, val_d;
  logic       vld_q, vld_d;
  logic [7:0] pat;

  // Pattern function of the counters being consumed this step.
  always_comb begin
    pat = 8'h00;
    if (PATTERN == 1) begin
      pat = h_q[7:0];
    end else if (PATTERN == 2) begin
      pat = {8{h_q[5] ^ v_q[5]}};
    end else begin
      pat = h_q[7:0] + v_q[7:0] + frame_q;
    end
  end

  // A pixel step is the clk edge on which pclk falls (pclk_q == 1).
  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    frame_d = frame_q;
    x_d     = x_q;
    y_d     = y_q;
    val_d   = val_q;
    vld_d   = vld_q;
    if (pclk_q) begin
      if (h_q < HA && v_q < VA) begin
        vld_d = 1'b1;
        x_d   = h_q;
        y_d   = v_q;
        val_d = pat;
      end else begin
        vld_d = 1'b0;
        val_d = 8'h00;
      end
      if (h_q == HL) begin
        h_d = 10'd0;
        if (v_q == VL) begin
          v_d     = 10'd0;
          frame_d = frame_q + 8'd1;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pclk_q  <= 1'b0;
      h_q     <= 10'd0;
      v_q     <= 10'd0;
      frame_q <= 8'd0;
      x_q     <= 10'd0;
      y_q     <= 10'd0;
      val_q   <= 8'd0;
      vld_q   <= 1'b0;
    end else begin
      pclk_q  <= ~pclk_q;
      h_q     <= h_d;
      v_q     <= v_d;
      frame_q <= frame_d;
      x_q     <= x_d;
      y_q     <= y_d;
      val_q   <= val_d;
      vld_q   <= vld_d;
    end
  end

  assign pclk   = pclk_q;
  assign value  = val_q;
  assign x      = x_q;
  assign y      = y_q;
  assign is_val = vld_q;

endmodule

// File: tb/tb_cam_sim.sv
// Directed self-checking bench for cam_sim: default geometry plus
// reduced geometries for frame-level, pattern and frame-wrap checks.
`timescale 1ns/1ps

module tb_cam_sim;

  typedef struct packed {
    logic       vld;
    logic [7:0] val;
    logic [9:0] x;
    logic [9:0] y;
  } pix_t;

  logic clk;
  logic reset;

  logic       d_pclk, s_pclk, p_pclk, t_pclk;
  logic [7:0] d_val, s_val, p_val, t_val;
  logic [9:0] d_x, s_x, p_x, t_x;
  logic [9:0] d_y, s_y, p_y, t_y;
  logic       d_vld, s_vld, p_vld, t_vld;

  int checks   = 0;
  int failures = 0;
  int steps    = -1;

  cam_sim u_def (
    .clk(clk), .reset(reset), .pclk(d_pclk), .value(d_val),
    .x(d_x), .y(d_y), .is_val(d_vld)
  );

  cam_sim #(.H_ACTIVE(128), .V_ACTIVE(60), .H_TOTAL(144),
            .V_TOTAL(64), .PATTERN(0)) u_sm (
    .clk(clk), .reset(reset), .pclk(s_pclk), .value(s_val),
    .x(s_x), .y(s_y), .is_val(s_vld)
  );

  cam_sim #(.H_ACTIVE(128), .V_ACTIVE(60), .H_TOTAL(144),
            .V_TOTAL(64), .PATTERN(2)) u_p2 (
    .clk(clk), .reset(reset), .pclk(p_pclk), .value(p_val),
    .x(p_x), .y(p_y), .is_val(p_vld)
  );

  cam_sim #(.H_ACTIVE(2), .V_ACTIVE(2), .H_TOTAL(3),
            .V_TOTAL(3), .PATTERN(0)) u_ti (
    .clk(clk), .reset(reset), .pclk(t_pclk), .value(t_val),
    .x(t_x), .y(t_y), .is_val(t_vld)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Expected output after pixel step s (0 = first step after reset).
  function automatic pix_t model(input int s, input int ha, input int ht,
                                 input int va, input int vt, input int pt);
    pix_t p;
    int fr, r, h, v;
    fr = s / (ht * vt);
    r  = s % (ht * vt);
    v  = r / ht;
    h  = r % ht;
    if (h < ha && v < va) begin
      p.vld = 1'b1;
      p.x   = 10'(h);
      p.y   = 10'(v);
      if (pt == 1)      p.val = 8'(h % 256);
      else if (pt == 2) p.val = (((h >> 5) ^ (v >> 5)) & 1) != 0 ? 8'hFF : 8'h00;
      else              p.val = 8'((h + v + fr) % 256);
    end else begin
      p.vld = 1'b0;
      p.val = 8'h00;
      p.x   = 10'(ha - 1);
      p.y   = (v < va) ? 10'(v) : 10'(va - 1);
    end
    return p;
  endfunction

  task automatic go_to(input int target);
    while (steps < target) begin
      repeat (2) @(posedge clk);
      #1;
      steps++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    steps = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #25;
    checks++;
    if ({d_pclk, d_val, d_x, d_y, d_vld} !== 29'd0) begin
      failures++;
      $display("FAIL reset_outputs got pclk=%b val=%0d x=%0d y=%0d vld=%b want all 0",
               d_pclk, d_val, d_x, d_y, d_vld);
    end
    @(negedge clk);
    reset = 1'b0;
    steps = -1;
    @(posedge clk); #1;
    checks++;
    if (d_pclk !== 1'b1 || d_vld !== 1'b0) begin
      failures++;
      $display("FAIL first_edge got pclk=%b vld=%b want pclk=1 vld=0", d_pclk, d_vld);
    end
    @(posedge clk); #1;
    steps = 0;
    checks++;
    if (d_pclk !== 1'b0 || d_x !== 10'd0 || d_y !== 10'd0 ||
        d_vld !== 1'b1 || d_val !== 8'd0) begin
      failures++;
      $display("FAIL first_pixel got pclk=%b x=%0d y=%0d vld=%b val=%0d want 0 0 0 1 0",
               d_pclk, d_x, d_y, d_vld, d_val);
    end
    @(posedge clk); #1;
    checks++;
    if (d_pclk !== 1'b1 || d_x !== 10'd0) begin
      failures++;
      $display("FAIL pclk_high got pclk=%b x=%0d want pclk=1 x=0", d_pclk, d_x);
    end
    @(posedge clk); #1;
    steps = 1;
    checks++;
    if (d_pclk !== 1'b0 || d_x !== 10'd1 || d_val !== 8'd1) begin
      failures++;
      $display("FAIL second_pixel got pclk=%b x=%0d val=%0d want 0 1 1",
               d_pclk, d_x, d_val);
    end
  endtask

  task automatic test_line();
    int bad, nv;
    pix_t e;
    bad = 0;
    nv  = 0;
    for (int i = 1; i < 784; i++) begin
      go_to(i);
      e = model(i, 640, 784, 480, 510, 0);
      if (d_vld) nv++;
      if ({d_vld, d_val, d_x, d_y} !== e) begin
        bad++;
        if (bad <= 4)
          $display("FAIL line_step%0d got vld=%b val=%0d x=%0d y=%0d want %b %0d %0d %0d",
                   i, d_vld, d_val, d_x, d_y, e.vld, e.val, e.x, e.y);
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL line_stream got %0d bad steps want 0", bad);
    end
    checks++;
    if (nv != 639) begin
      failures++;
      $display("FAIL line_valid_count got %0d want 639 (after step 0)", nv);
    end
    go_to(784);
    checks++;
    if (d_x !== 10'd0 || d_y !== 10'd1 || d_vld !== 1'b1 || d_val !== 8'd1) begin
      failures++;
      $display("FAIL next_line got x=%0d y=%0d vld=%b val=%0d want 0 1 1 1",
               d_x, d_y, d_vld, d_val);
    end
  endtask

  task automatic test_pattern0();
    go_to(50 * 144 + 100);
    checks++;
    if (s_x !== 10'd100 || s_y !== 10'd50 || s_val !== 8'd150) begin
      failures++;
      $display("FAIL pat0_mid got x=%0d y=%0d val=%0d want 100 50 150", s_x, s_y, s_val);
    end
    go_to(59 * 144 + 127);
    checks++;
    if (s_x !== 10'd127 || s_y !== 10'd59 || s_val !== 8'd186 || s_vld !== 1'b1) begin
      failures++;
      $display("FAIL pat0_last got x=%0d y=%0d val=%0d vld=%b want 127 59 186 1",
               s_x, s_y, s_val, s_vld);
    end
    go_to(59 * 144 + 128);
    checks++;
    if (s_vld !== 1'b0 || s_val !== 8'd0 || s_x !== 10'd127) begin
      failures++;
      $display("FAIL pat0_hblank got vld=%b val=%0d x=%0d want 0 0 127", s_vld, s_val, s_x);
    end
  endtask

  task automatic test_frame();
    int nv;
    nv = 0;
    go_to(9216);
    checks++;
    if (s_x !== 10'd0 || s_y !== 10'd0 || s_vld !== 1'b1 || s_val !== 8'd1) begin
      failures++;
      $display("FAIL frame1_origin got x=%0d y=%0d vld=%b val=%0d want 0 0 1 1",
               s_x, s_y, s_vld, s_val);
    end
    for (int i = 9216; i < 18432; i++) begin
      go_to(i);
      if (s_vld === 1'b1) nv++;
    end
    checks++;
    if (nv != 7680) begin
      failures++;
      $display("FAIL frame_valid_count got %0d want 7680", nv);
    end
    checks++;
    if (s_vld !== 1'b0 || s_y !== 10'd59 || s_x !== 10'd127) begin
      failures++;
      $display("FAIL vblank_hold got vld=%b x=%0d y=%0d want 0 127 59", s_vld, s_x, s_y);
    end
    go_to(18432);
    checks++;
    if (s_val !== 8'd2 || s_vld !== 1'b1) begin
      failures++;
      $display("FAIL frame2_origin got val=%0d vld=%b want 2 1", s_val, s_vld);
    end
  endtask

  task automatic test_mid_reset();
    go_to(steps + 3);
    checks++;
    if (d_vld !== 1'b1 || d_x === 10'd0) begin
      failures++;
      $display("FAIL pre_reset got vld=%b x=%0d want vld=1 x!=0", d_vld, d_x);
    end
    @(posedge clk); #4;
    reset = 1'b1;
    #2;
    checks++;
    if ({d_pclk, d_val, d_x, d_y, d_vld} !== 29'd0 ||
        {s_val, s_x, s_y, s_vld} !== 29'd0) begin
      failures++;
      $display("FAIL async_reset got pclk=%b val=%0d x=%0d y=%0d vld=%b want all 0",
               d_pclk, d_val, d_x, d_y, d_vld);
    end
    @(negedge clk);
    reset = 1'b0;
    steps = -1;
    @(posedge clk); #1;
    checks++;
    if (d_pclk !== 1'b1 || d_vld !== 1'b0) begin
      failures++;
      $display("FAIL restart_edge1 got pclk=%b vld=%b want 1 0", d_pclk, d_vld);
    end
    @(posedge clk); #1;
    steps = 0;
    checks++;
    if (d_x !== 10'd0 || d_y !== 10'd0 || d_vld !== 1'b1 || d_val !== 8'd0 ||
        s_val !== 8'd0) begin
      failures++;
      $display("FAIL restart_pixel got x=%0d y=%0d vld=%b val=%0d want 0 0 1 0",
               d_x, d_y, d_vld, d_val);
    end
  endtask

  task automatic test_pattern2();
    logic [7:0] want [4];
    int idx [4];
    idx[0] = 0;      want[0] = 8'h00;
    idx[1] = 32;     want[1] = 8'hFF;
    idx[2] = 4608;   want[2] = 8'hFF;
    idx[3] = 4640;   want[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      go_to(idx[i]);
      checks++;
      if (p_val !== want[i] || p_vld !== 1'b1) begin
        failures++;
        $display("FAIL pat2_x%0d_y%0d got val=%h vld=%b want %h 1",
                 idx[i] % 144, idx[i] / 144, p_val, p_vld, want[i]);
      end
    end
  endtask

  task automatic test_frame_wrap();
    logic [7:0] want [4];
    int idx [4];
    do_reset();
    idx[0] = 2295;  want[0] = 8'd255;
    idx[1] = 2299;  want[1] = 8'd1;
    idx[2] = 2304;  want[2] = 8'd0;
    idx[3] = 2313;  want[3] = 8'd1;
    for (int i = 0; i < 4; i++) begin
      go_to(idx[i]);
      checks++;
      if (t_val !== want[i] || t_vld !== 1'b1) begin
        failures++;
        $display("FAIL wrap_step%0d got val=%0d vld=%b want %0d 1",
                 idx[i], t_val, t_vld, want[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_line();
    test_pattern0();
    test_frame();
    test_mid_reset();
    test_pattern2();
    test_frame_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cam_sim.md
# cam_sim

Synthetic camera source for simulation and bring-up of the stereo capture path. It emulates a VGA-resolution image sensor: it divides the system clock into a pixel clock and streams one 8-bit pixel per pixel-clock period with its (x, y) coordinates and a valid flag. It sits upstream of the VGA frame-buffer writer (vga_buf_sim), which samples its outputs on rising `pclk`.

## Interface
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `H_TOTAL`, 784: pixel steps per line, including blanking; must exceed `H_ACTIVE`.
- `V_TOTAL`, 510: lines per frame, including blanking; must exceed `V_ACTIVE`.
- `PATTERN`, 0: 0 = diagonal ramp, 1 = horizontal ramp, 2 = 32-pixel checkerboard.
- `clk`  in  1  system clock; all logic runs on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pclk`  out  1  pixel clock, clk/2, registered.
- `value`  out  8  pixel intensity.
- `x`  out  10  column of the current pixel, 0..H_ACTIVE-1.
- `y`  out  10  row of the current pixel, 0..V_ACTIVE-1.
- `is_val`  out  1  high while `value`/`x`/`y` describe an active pixel.

## Operation
- Internal state:
  - `h_cnt`, 10 bits, 0..H_TOTAL-1.
  - `v_cnt`, 10 bits, 0..V_TOTAL-1.
  - `frame`, 8 bits, wraps 255→0.
  - `pclk` register.
- `pclk` toggles on every `clk` rising edge.
- A pixel step is a `clk` edge on which `pclk` is currently 1, so `pclk` falls on that edge.
- On each pixel step, if `h_cnt < H_ACTIVE` and `v_cnt < V_ACTIVE` (active region):
  - `is_val` ← 1, `x` ← `h_cnt`, `y` ← `v_cnt`.
  - `value` ← f(`h_cnt`, `v_cnt`, `frame`).
- Otherwise (blanking): `is_val` ← 0, `value` ← 0, `x`/`y` hold their previous values.
- Counter advance, same pixel step: `h_cnt` increments.
  - At `H_TOTAL-1`, `h_cnt` wraps to 0 and `v_cnt` increments.
  - At `v_cnt = V_TOTAL-1` with `h_cnt = H_TOTAL-1`, `v_cnt` wraps to 0 and `frame` increments mod 256.
- Pattern f, computed with 8-bit wrap:
  - 0: (h + v + frame) mod 256.
  - 1: h[7:0].
  - 2: 8'hFF if h[5] XOR v[5], else 8'h00.
- Free-running: no enable, no back-pressure; the consumer must accept every valid pixel.

## Timing
- Reset (asynchronous, immediate):
  - Outputs: `pclk`=0, `value`=0, `x`=0, `y`=0, `is_val`=0.
  - Internal: `h_cnt`=`v_cnt`=`frame`=0.
- After reset deasserts:
  - 1st `clk` edge: `pclk`→1.
  - 2nd edge: `pclk`→0, first pixel step; outputs x=0, y=0, is_val=1, value=f(0,0,0).
- Outputs change only on falling `pclk` (pixel steps). They are stable for a full `pclk` period around each rising `pclk`, which is where the consumer samples.
- Latency: pixel (h, v) appears on the outputs on the same edge its counters are consumed; no extra pipeline stage.
- Line = `H_TOTAL` pixel steps = 2·`H_TOTAL` clk cycles (1568 at defaults).
- Frame = `H_TOTAL`·`V_TOTAL` pixel steps (399840 at defaults).
- `is_val` high for exactly `H_ACTIVE` consecutive pixel steps per active line and low for the remaining `H_TOTAL-H_ACTIVE`. It stays low for whole lines `V_ACTIVE..V_TOTAL-1`.
- Reset asserted mid-frame: all state returns to reset values at once. The next frame restarts at (0,0) with `frame`=0.
- `frame` wrap 255→0 is silent; pattern 0 continues with 8-bit modular arithmetic.

## Test plan
- Reset hold 30 ns then release (10 ns clk half-period): `pclk`=0 and all outputs 0 during reset. `pclk` period 40 ns after release; first pixel x=0, y=0, is_val=1, value=0.
- Run one line at defaults:
  - is_val high for exactly 640 pixel steps, x counts 0..639, then low for 144 steps with x held at 639.
  - Next active pixel: x=0, y=1, value=1.
- Pattern 0 value checks: at (x=100, y=200, frame 0) value=44 (300 mod 256). At (639, 479) value=(1118 mod 256)=94.
- Full frame: count valid pixels = 307200. Second frame pixel (0,0) has value=1, confirming `frame`=1.
- Assert `reset` mid-line at x≈300, y≈50 for one clk: outputs go to 0 asynchronously, before the next clk edge. Stream restarts at (0,0), value 0, two clk edges after release.
- PATTERN=2: value 0x00 at (0,0) and (32,32). Value 0xFF at (32,0) and (0,32).
